// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the E-stage multiply/divide controller: MD op codes,
// core op codes, FSM states and the decoded-op bundle.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    CORE_NONE = 2'd0,
    CORE_MUL  = 2'd1,
    CORE_DIV  = 2'd2
  } core_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic     is_start;
    logic     is_mt_hi;
    logic     is_mt_lo;
    core_op_e op;
    logic     sign;
  } md_dec_t;

endpackage

// File: rtl/md_ctrl_if.sv
// Valid/ready link between the MD controller and the multi-cycle MD core.
interface md_ctrl_if;
  logic        core_in_valid;
  logic        core_in_ready;
  logic [1:0]  core_op;
  logic        core_sign;
  logic [31:0] core_src0;
  logic [31:0] core_src1;
  logic        core_out_valid;
  logic        core_out_ready;
  logic [31:0] core_res0;
  logic [31:0] core_res1;

  modport master (
    output core_in_valid, core_op, core_sign, core_src0, core_src1, core_out_ready,
    input  core_in_ready, core_out_valid, core_res0, core_res1
  );

  modport slave (
    input  core_in_valid, core_op, core_sign, core_src0, core_src1, core_out_ready,
    output core_in_ready, core_out_valid, core_res0, core_res1
  );
endinterface

// File: rtl/md_op_decode.sv
// Combinational decode of the E-stage MD op into start/move-to flags and
// the core op/sign it maps to. Reserved code 7 decodes as a NOP.
module md_op_decode
  import md_ctrl_pkg::*;
(
  input  logic [2:0] e_op,
  output md_dec_t    dec
);

  always_comb begin
    dec = '0;
    case (md_op_e'(e_op))
      MD_MULT:  begin dec.is_start = 1'b1; dec.op = CORE_MUL; dec.sign = 1'b1; end
      MD_MULTU: begin dec.is_start = 1'b1; dec.op = CORE_MUL; end
      MD_DIV:   begin dec.is_start = 1'b1; dec.op = CORE_DIV; dec.sign = 1'b1; end
      MD_DIVU:  begin dec.is_start = 1'b1; dec.op = CORE_DIV; end
      MD_MTLO:  dec.is_mt_lo = 1'b1;
      MD_MTHI:  dec.is_mt_hi = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// E-stage MD sequencer: latches an op, hands it to the MD core over
// valid/ready, retires the result into HI/LO and raises the D-stage stall.
module md_ctrl
  import md_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_src_a,
  input  logic [31:0] e_src_b,
  input  logic        req,
  input  logic        d_uses_md,
  md_ctrl_if.master   core,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  md_dec_t     dec;
  state_e      state_q, state_d;
  core_op_e    op_q;
  logic        sign_q;
  logic [31:0] a_q, b_q;
  logic        start_e, idle;

  md_op_decode u_dec (
    .e_op (e_op),
    .dec  (dec)
  );

  // A flushed op never starts; an op arriving while busy is dropped by the FSM.
  assign start_e = dec.is_start & ~req;
  assign idle    = (state_q == S_IDLE);
  assign busy    = ~idle;
  assign stall   = d_uses_md & (busy | start_e);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    core.core_in_valid  = 1'b0;
    core.core_out_ready = 1'b0;
    case (state_q)
      S_IDLE:  if (start_e) state_d = S_ISSUE;
      S_ISSUE: begin
        core.core_in_valid = 1'b1;
        if (core.core_in_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        core.core_out_ready = 1'b1;
        if (core.core_out_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= CORE_NONE;
      sign_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (idle && start_e) begin
      op_q   <= dec.op;
      sign_q <= dec.sign;
      a_q    <= e_src_a;
      b_q    <= e_src_b;
    end
  end

  // Divide-by-zero results are committed as the core produced them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (idle && !req && dec.is_mt_lo) begin
      lo <= e_src_a;
    end else if (idle && !req && dec.is_mt_hi) begin
      hi <= e_src_a;
    end else if (state_q == S_WAIT && core.core_out_valid) begin
      hi <= core.core_res1;
      lo <= core.core_res0;
    end
  end

  assign core.core_op   = busy ? op_q   : CORE_NONE;
  assign core.core_sign = busy ? sign_q : 1'b0;
  assign core.core_src0 = busy ? a_q    : '0;
  assign core.core_src1 = busy ? b_q    : '0;

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Sequencing controller for the E-stage multiply/divide unit. It accepts MD operations from the E stage, drives the multi-cycle MD core through its valid/ready handshakes and owns the HI/LO architectural registers. It also produces the D-stage stall and suppresses operations flushed by `req` (exception/interrupt). It sits between the E-stage pipeline register and the MD core, replacing any combinational glue between them.

## Interface
Parameters: none (widths fixed at 32-bit datapath).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low. 0 clears all state immediately.
- `e_op` in 3: E-stage MD op. 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTLO, 6 MTHI, 7 reserved (treated as NOP).
- `e_src_a` in 32: rs value (dividend/multiplicand; MTHI/MTLO source).
- `e_src_b` in 32: rt value.
- `req` in 1: E-stage instruction is being flushed this cycle.
- `d_uses_md` in 1: D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- `core_in_valid` out 1: operation offered to core.
- `core_in_ready` in 1: core accepts operation.
- `core_op` out 2: 1 multiply, 2 divide, 0 otherwise.
- `core_sign` out 1: 1 signed.
- `core_src0` out 32: operand A.
- `core_src1` out 32: operand B.
- `core_out_valid` in 1: core result available.
- `core_out_ready` out 1: controller accepts result.
- `core_res0` in 32: LO result (product low / quotient).
- `core_res1` in 32: HI result (product high / remainder).
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `busy` out 1: an MD operation is in flight.
- `stall` out 1: hold D stage.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- A start is `e_op` in 1..4 with `req`=0.
- IDLE:
  - On start, latch operands, op and sign into registers; go to ISSUE.
  - On `e_op` 5/6 with `req`=0, write `e_src_a` to LO/HI at the edge; stay in IDLE.
  - With `req`=1, no state changes.
- ISSUE:
  - `core_in_valid`=1 with the latched operands/op/sign held stable.
  - On `core_in_valid & core_in_ready`, go to WAIT.
- WAIT:
  - `core_out_ready`=1.
  - On `core_out_valid`, write LO←`core_res0` and HI←`core_res1`; go to IDLE.
- `core_out_valid` outside WAIT is ignored. `core_out_ready`=0 outside WAIT.
- `busy` = (state≠IDLE).
- `stall` = `d_uses_md` & (`busy` | start).
- Any `e_op` arriving while `busy` is a protocol violation. It is ignored: no latch, no HI/LO write.
- `req` affects only the op presently in E. It never cancels an operation already in ISSUE/WAIT, because that operation has committed.
- Divide by zero: core results are written unmodified; no trap.
- `core_op`/`core_sign`/`core_src*` are driven from the latch registers and are 0 in IDLE.

## Timing
- Reset (`reset`=0) values: state IDLE; `hi`=`lo`=0; `busy`=`stall`=0; all `core_*` outputs 0.
- Start in cycle t → ISSUE and `busy`=1 from t+1. `stall` is already 1 in t if `d_uses_md`.
- Handshake accepted in cycle k≥t+1 → WAIT from k+1.
- `core_out_valid` in cycle m≥k+1 → `hi`/`lo` updated and `busy`=0 from m+1.
- Minimum start-to-IDLE latency: 3 cycles plus core latency.
- MTHI/MTLO: `hi`/`lo` visible the cycle after the op is in E.
- Back-to-back: a new start is accepted in cycle m+1.
- Reset asserted mid-operation: return to IDLE asynchronously, HI/LO cleared, and `core_in_valid` dropped. The core must be reset by the same signal.

## Structure
- Shared package:
  - MD op encoding constants (NOP, MULT, MULTU, DIV, DIVU, MTLO, MTHI).
  - `core_op` codes.
  - FSM state typedef.
- One natural combinational sub-module, `md_op_decode`: `e_op` → {is_start, is_mt_hi, is_mt_lo, core_op, core_sign}.
- FSM, operand latches and HI/LO registers are in `md_ctrl`.

## Test plan
- MULT with src_a=0xFFFFFFFE, src_b=3, core returns {res1=0xFFFFFFFF, res0=0xFFFFFFFA} after a 5-cycle WAIT → `core_sign`=1, `core_op`=1; `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFA one cycle after `out_valid`; `busy` high for exactly the ISSUE+WAIT cycles.
- DIVU 7/2 with `core_in_ready` held low 3 cycles → `core_in_valid` and operands stable throughout; `hi`=1 and `lo`=3 after the result.
- DIV with `req`=1 in the start cycle → no `core_in_valid`, `busy` stays 0, `hi`/`lo` unchanged.
- MTHI 0x12345678 during `busy` (violation) → ignored; a subsequent MTHI in IDLE → `hi`=0x12345678 next cycle.
- `d_uses_md`=1 during start and WAIT → `stall`=1 from the start cycle until `busy` falls. Then assert `reset`=0 mid-WAIT → `busy`, `hi`, `lo` and `core_in_valid` go to 0 immediately.
